regfile_writeback_queue: RTL and testbench

- Collects register-file write requests from the ALU result path and the load/memory path.
- Buffers them in a small in-order FIFO and drains exactly one write per cycle onto the register file write port (`write_reg`, `write_data`, `RegWrite`).
- Provides a pending-write lookup on two source registers so the issue stage can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_writeback_queue.sv | 129 ++++++++++++
 tb/tb_regfile_writeback_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue
// Collects register-file writes from the ALU result path and the load path,
// buffers them in a small in-order FIFO and drains one write per cycle onto
// the register file write port. It also answers pending-write queries so the
// issue stage can stall on read-after-write hazards.
//
// Ports:
//   clk, reset                   clock (posedge) and async active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU writeback request channel
//   mem_valid/mem_ready/mem_rd/mem_data   load writeback request channel
//   chk_rs1/chk_rs2              hazard query registers
//   pend_rs1/pend_rs2            query register has a write queued or in flight
//   write_reg/write_data/RegWrite registered register file write port
//   count                        current FIFO occupancy, 0..DEPTH
module regfile_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [4:0]    mem_rd,
    input  logic [31:0]   mem_data,
    input  logic [4:0]    chk_rs1,
    input  logic [4:0]    chk_rs2,
    output logic          pend_rs1,
    output logic          pend_rs2,
    output logic [4:0]    write_reg,
    output logic [31:0]   write_data,
    output logic          RegWrite,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LEFT = (AW+1)'(DEPTH - 1);

    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] alu_slot;
    logic [DEPTH-1:0] entry_valid;

    logic mem_fire;
    logic alu_fire;
    logic mem_push;
    logic alu_push;
    logic pop;

    // Readiness looks only at the registered occupancy, so a pop in the same
    // cycle never creates room. When a single slot is left, the load path
    // gets it and the ALU is held off.
    assign mem_ready = (count < FULL);
    assign alu_ready = (count < ONE_LEFT) || ((count == ONE_LEFT) && !mem_valid);

    // Writes to x0 complete their handshake but are dropped here.
    assign mem_fire = mem_valid && mem_ready;
    assign alu_fire = alu_valid && alu_ready;
    assign mem_push = mem_fire && (mem_rd != 5'd0);
    assign alu_push = alu_fire && (alu_rd != 5'd0);
    assign pop      = (count != '0);

    // The load entry is older, so the ALU entry lands behind it.
    assign alu_slot = wr_ptr + AW'(mem_push);

    // Entry storage needs no reset; occupancy alone defines which slots count.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            rd_q[wr_ptr]   <= mem_rd;
            data_q[wr_ptr] <= mem_data;
        end
        if (alu_push) begin
            rd_q[alu_slot]   <= alu_rd;
            data_q[alu_slot] <= alu_data;
        end
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            write_reg  <= '0;
            write_data <= '0;
            RegWrite   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(mem_push) + AW'(alu_push);
            count  <= count + (AW+1)'(mem_push) + (AW+1)'(alu_push) - (AW+1)'(pop);
            if (pop) begin
                write_reg  <= rd_q[rd_ptr];
                write_data <= data_q[rd_ptr];
                RegWrite   <= 1'b1;
                rd_ptr     <= rd_ptr + 1'b1;
            end else begin
                RegWrite   <= 1'b0;
            end
        end
    end

    // A slot is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, AW'(i) - rd_ptr} < count);
        end
    end

    // Hazard lookup covers queued entries plus the write on the port now.
    always_comb begin
        pend_rs1 = 1'b0;
        pend_rs2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (rd_q[i] == chk_rs1)) pend_rs1 = 1'b1;
            if (entry_valid[i] && (rd_q[i] == chk_rs2)) pend_rs2 = 1'b1;
        end
        if (RegWrite && (write_reg == chk_rs1)) pend_rs1 = 1'b1;
        if (RegWrite && (write_reg == chk_rs2)) pend_rs2 = 1'b1;
        if (chk_rs1 == 5'd0) pend_rs1 = 1'b0;
        if (chk_rs2 == 5'd0) pend_rs2 = 1'b0;
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue
// Self-checking bench for regfile_writeback_queue. A queue-based reference
// model tracks what the writeback FIFO should hold and what the register
// file port should show, using directed steps followed by random traffic.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic          clk;
    logic          reset;
    logic          alu_valid;
    logic          alu_ready;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_rd;
    logic [31:0]   mem_data;
    logic [4:0]    chk_rs1;
    logic [4:0]    chk_rs2;
    logic          pend_rs1;
    logic          pend_rs2;
    logic [4:0]    write_reg;
    logic [31:0]   write_data;
    logic          RegWrite;
    logic [AW:0]   count;

    // Reference model state
    wb_t         model_q[$];
    logic        m_regwrite;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    int total;
    int bad;

    regfile_writeback_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .pend_rs1   (pend_rs1),
        .pend_rs2   (pend_rs2),
        .write_reg  (write_reg),
        .write_data (write_data),
        .RegWrite   (RegWrite),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_pend(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        foreach (model_q[i]) if (model_q[i].rd == rs) return 1'b1;
        return m_regwrite && (m_wreg == rs);
    endfunction

    function automatic logic model_mem_ready();
        return model_q.size() < DEPTH;
    endfunction

    function automatic logic model_alu_ready(input logic mv);
        return (model_q.size() < DEPTH - 1) || ((model_q.size() == DEPTH - 1) && !mv);
    endfunction

    // Compare every observable output against the model's current view.
    task automatic checkOutput();
        check("count",      32'(count),      32'(model_q.size()));
        check("RegWrite",   32'(RegWrite),   32'(m_regwrite));
        check("write_reg",  32'(write_reg),  32'(m_wreg));
        check("write_data", write_data,      m_wdata);
        check("mem_ready",  32'(mem_ready),  32'(model_mem_ready()));
        check("alu_ready",  32'(alu_ready),  32'(model_alu_ready(mem_valid)));
        check("pend_rs1",   32'(pend_rs1),   32'(model_pend(chk_rs1)));
        check("pend_rs2",   32'(pend_rs2),   32'(model_pend(chk_rs2)));
    endtask

    // One clock cycle: drive at negedge, check, then advance the model at posedge.
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                 input logic [4:0] rs1, input logic [4:0] rs2);
        logic mr;
        logic ar;
        wb_t  head;
        @(negedge clk);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        mem_valid = mv;
        mem_rd    = mrd;
        mem_data  = md;
        chk_rs1   = rs1;
        chk_rs2   = rs2;
        #1;
        checkOutput();
        mr = model_mem_ready();
        ar = model_alu_ready(mv);
        @(posedge clk);
        if (model_q.size() > 0) begin
            head       = model_q.pop_front();
            m_wreg     = head.rd;
            m_wdata    = head.data;
            m_regwrite = 1'b1;
        end else begin
            m_regwrite = 1'b0;
        end
        if (mv && mr && (mrd != 5'd0)) model_q.push_back('{rd: mrd, data: md});
        if (av && ar && (ard != 5'd0)) model_q.push_back('{rd: ard, data: ad});
    endtask

    task automatic idle(input int n, input logic [4:0] rs1, input logic [4:0] rs2);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rs1, rs2);
    endtask

    // Assert reset away from any edge and check the outputs clear at once.
    task automatic doReset();
        #2;
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        chk_rs1   = 5'd0;
        chk_rs2   = 5'd0;
        reset     = 1'b1;
        #1;
        model_q.delete();
        m_regwrite = 1'b0;
        m_wreg     = 5'd0;
        m_wdata    = 32'd0;
        checkOutput();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        alu_valid = 1'b0;
        alu_rd    = 5'd0;
        alu_data  = 32'd0;
        mem_valid = 1'b0;
        mem_rd    = 5'd0;
        mem_data  = 32'd0;
        chk_rs1   = 5'd0;
        chk_rs2   = 5'd0;
        model_q.delete();
        m_regwrite = 1'b0;
        m_wreg     = 5'd0;
        m_wdata    = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        idle(2, 5'd1, 5'd0);

        $display("[TB] reset then idle");
        doReset();
        idle(2, 5'd5, 5'd0);

        $display("[TB] single ALU write");
        applyStimulus(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6);
        idle(4, 5'd5, 5'd6);

        $display("[TB] dual push ordering");
        applyStimulus(1'b1, 5'd3, 32'h22, 1'b1, 5'd3, 32'h11, 5'd3, 5'd0);
        idle(4, 5'd3, 5'd0);

        $display("[TB] fill and backpressure");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 5'(2 * i + 1), 32'h100 + 32'(i), 1'b1, 5'(2 * i + 2), 32'h200 + 32'(i),
                          5'(2 * i + 1), 5'(2 * i + 2));
        end
        idle(6, 5'd19, 5'd20);

        $display("[TB] x0 drop");
        applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idle(3, 5'd0, 5'd0);

        $display("[TB] reset mid-drain");
        applyStimulus(1'b1, 5'd10, 32'hA10, 1'b1, 5'd11, 32'hB11, 5'd10, 5'd12);
        applyStimulus(1'b1, 5'd12, 32'hC12, 1'b0, 5'd0, 32'd0, 5'd10, 5'd12);
        doReset();
        idle(5, 5'd10, 5'd12);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(6, 5'd1, 5'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
